alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 4-bit alu instance (ports oc, a, b, f) between two requesters.
- Each requester submits an operation over a valid/ready handshake and gets the result back over its own valid/ready response channel.
- Arbitration is round-robin, with one operation in flight at a time.
- Sits between control logic that needs ALU work and the alu datapath.

Parameters:
- WIDTH, 4, operand/result width; must match alu.
- OC_W, 3, opcode width; must match alu.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts requester 0's operation this cycle.
- req0_oc  in  OC_W  requester 0 opcode; passed to alu unchanged.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- resp0_valid  out  1  result for requester 0 is available.
- resp0_ready  in  1  requester 0 takes the result.
- resp0_f  out  WIDTH  result for requester 0.
- req1_valid, req1_ready, req1_oc, req1_a, req1_b, resp1_valid, resp1_ready, resp1_f: same as requester 0, for requester 1.
- busy  out  1  high in every state except IDLE.
- done_count  out  CNT_W  number of completed response handshakes; wraps.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - Operand registers = 0; result register = 0; done_count = 0.
  - All ready/valid outputs = 0; resp0_f = resp1_f = 0.
- Reset mid-operation discards the in-flight operation with no response. The next cycle after rst falls is IDLE.
- States: IDLE, EXEC, RESP. There is a single grant register, g.
- IDLE:
  - Grant is combinational from req*_valid and last_grant.
  - Only one valid: grant that requester.
  - Both valid: grant the requester not equal to last_grant.
  - reqG_ready = 1 for the granted requester only, and only in IDLE. The other ready stays 0.
  - When reqG_valid && reqG_ready: capture oc, a, b into the operand registers and g <= G. Go to EXEC.
  - No valid: stay in IDLE; all ready = 0.
- EXEC:
  - alu inputs are driven only from the operand registers, never from the req ports.
  - The result register captures alu f. Go to RESP.
- RESP:
  - respG_valid = 1 and respG_f = result register. The other response valid stays 0.
  - respG_f and respG_valid stay stable until respG_ready = 1.
  - On respG_ready: last_grant <= g, done_count <= done_count + 1 (mod 2^CNT_W). Go to IDLE.
  - respG_ready may be held high in advance; the handshake then completes on the first RESP cycle.
- Timing:
  - Accept in cycle N gives respG_valid in cycle N+2.
  - Minimum spacing between accepts is 3 cycles.
  - The response-to-next-accept gap is 1 cycle; no accept happens in the same cycle as a response.
- The non-granted response port drives resp_f = 0.
- Requests arriving in EXEC or RESP see ready = 0 and must hold valid. The arbiter never drops an asserted request.
- Requesters may change oc/a/b after acceptance without affecting the result.
- Width rule: results are exactly as alu produces them, WIDTH bits, with no extension or carry-out.
- Opcode rule: oc is opaque to the arbiter; every OC_W value is forwarded.

Decomposition:
- Package alu_arb_pkg holds:
  - WIDTH and OC_W defaults.
  - The state enum: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
  - The requester-index typedef (1 bit).
- One sub-module instance: alu (existing, combinational), named u_alu. The arbiter FSM and round-robin logic stay in alu_arbiter.

Test Plan:
- Single request:
  - Stimulus: rst pulse, then req0_valid = 1 with oc = 3'b000, a = 4'h3, b = 4'h5; resp0_ready = 1.
  - Required: req0_ready = 1 in the first IDLE cycle, and resp0_valid exactly 2 cycles after acceptance.
  - Required: resp0_f equals a standalone alu output for (000, 3, 5); resp1_valid stays 0; done_count = 1.
- Tie after reset:
  - Stimulus: both valid in the same cycle, req0 (oc = 3'b001, a = 4'hA, b = 4'h6), req1 (oc = 3'b010, a = 4'hF, b = 4'h1).
  - Required: req0 is served first; req1 is accepted on the cycle after resp0's handshake.
  - Required: done_count = 2 after both responses.
- Round-robin fairness:
  - Stimulus: both requesters held valid for 8 operations.
  - Required: grants alternate 0,1,0,1,...; done_count = 8.
- Response backpressure:
  - Stimulus: resp1_ready held 0 for 5 cycles during requester 1's response.
  - Required: resp1_valid and resp1_f stay stable; busy = 1; req0_ready = 0 throughout.
  - Required: the handshake completes once resp1_ready = 1.
- Exhaustive opcodes:
  - Stimulus: all 2^11 (oc, a, b) triples through requester 0.
  - Required: every resp0_f matches a standalone alu instance fed the same triple.
  - Required: done_count wraps 255 -> 0 correctly.
- Mid-operation reset:
  - Stimulus: assert rst in the EXEC cycle.
  - Required: all valid/ready outputs = 0 immediately (asynchronously); done_count = 0; no response is issued.
  - Required: after release, a tie again grants requester 0 first.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the two-requester ALU arbiter and its ALU.
package alu_arb_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_OC_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic req_idx_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's operation channel plus its response channel.
interface alu_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OC_W  = DEF_OC_W
);
    logic             req_valid;
    logic             req_ready;
    logic [OC_W-1:0]  oc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_f;

    modport master (
        output req_valid, oc, a, b, resp_ready,
        input  req_ready, resp_valid, resp_f
    );

    modport slave (
        input  req_valid, oc, a, b, resp_ready,
        output req_ready, resp_valid, resp_f
    );
endinterface

// File: rtl/alu.sv
// Combinational 4-bit ALU; results wrap to WIDTH bits, no carry-out.
module alu
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OC_W  = DEF_OC_W
) (
    input  logic [OC_W-1:0]  oc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = '0;
        case (oc)
            OP_ADD:  f = a + b;
            OP_SUB:  f = a - b;
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_XOR:  f = a ^ b;
            OP_NOT:  f = ~a;
            OP_SHL:  f = a << 1;
            default: f = a >> 1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation in flight.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OC_W  = DEF_OC_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     req0,
    alu_arbiter_if.slave     req1,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    state_e           state_q, state_d;
    req_idx_t         last_grant_q, last_grant_d;
    req_idx_t         g_q, g_d;
    req_idx_t         grant;
    logic             grant_vld;
    logic             resp_ready_g;
    logic [OC_W-1:0]  oc_q, oc_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] alu_f;
    logic [CNT_W-1:0] done_count_q, done_count_d;

    // The ALU only ever sees registered operands, so requesters may change theirs after accept.
    alu #(.WIDTH(WIDTH), .OC_W(OC_W)) u_alu (
        .oc (oc_q),
        .a  (a_q),
        .b  (b_q),
        .f  (alu_f)
    );

    always_comb begin
        grant_vld = req0.req_valid | req1.req_valid;
        if (req0.req_valid && req1.req_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1.req_valid;
        end
        resp_ready_g = g_q ? req1.resp_ready : req0.resp_ready;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        g_d          = g_q;
        oc_d         = oc_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        done_count_d = done_count_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    g_d     = grant;
                    oc_d    = grant ? req1.oc : req0.oc;
                    a_d     = grant ? req1.a : req0.a;
                    b_d     = grant ? req1.b : req0.b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_f;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready_g) begin
                    last_grant_d = g_q;
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked by rst so every handshake output drops the instant reset asserts.
    always_comb begin
        req0.req_ready  = 1'b0;
        req1.req_ready  = 1'b0;
        req0.resp_valid = 1'b0;
        req1.resp_valid = 1'b0;
        req0.resp_f     = '0;
        req1.resp_f     = '0;
        if (!rst && state_q == IDLE && grant_vld) begin
            req0.req_ready = ~grant;
            req1.req_ready = grant;
        end
        if (state_q == RESP) begin
            if (g_q) begin
                req1.resp_valid = 1'b1;
                req1.resp_f     = res_q;
            end else begin
                req0.resp_valid = 1'b1;
                req0.resp_f     = res_q;
            end
        end
        busy       = (state_q != IDLE);
        done_count = done_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            g_q          <= 1'b0;
            oc_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            g_q          <= g_d;
            oc_q         <= oc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            done_count_q <= done_count_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] done_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt      = 0;   // expected completed responses
    int last     = 1;   // requester served most recently
    int cyc      = 0;
    int acc_cyc  = 0;
    int hs_cyc   = 0;

    alu_arbiter_if i0 ();
    alu_arbiter_if i1 ();

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (i0),
        .req1       (i1),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] alu_ref(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        int r;
        int ia = int'(a);
        int ib = int'(b);
        case (oc)
            3'd0:    r = ia + ib;
            3'd1:    r = ia - ib + 16;
            3'd2:    r = ia & ib;
            3'd3:    r = ia | ib;
            3'd4:    r = ia ^ ib;
            3'd5:    r = 15 - ia;
            3'd6:    r = ia * 2;
            default: r = ia / 2;
        endcase
        r = r % 16;
        return r[3:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        if (r == 0) begin
            i0.req_valid = v; i0.oc = oc; i0.a = a; i0.b = b;
        end else begin
            i1.req_valid = v; i1.oc = oc; i1.a = a; i1.b = b;
        end
    endtask

    task automatic set_valid(input int r, input logic v);
        if (r == 0) i0.req_valid = v;
        else        i1.req_valid = v;
    endtask

    task automatic rand_req(input int r);
        logic [31:0] rnd;
        rnd = $urandom;
        set_req(r, 1'b1, rnd[2:0], rnd[7:4], rnd[11:8]);
    endtask

    task automatic set_resp_ready(input int r, input logic v);
        if (r == 0) i0.resp_ready = v;
        else        i1.resp_ready = v;
    endtask

    task automatic do_reset();
        i0.req_valid = 1'b0;
        i1.req_valid = 1'b0;
        rst = 1'b1;
        to_next();
        rst = 1'b0;
        cnt  = 0;
        last = 1;
    endtask

    // Waits for one accept, checks arbitration against the model, then follows the operation
    // through EXEC and RESP (holding resp_ready low for bp RESP cycles). Ends in the last RESP cycle.
    task automatic serve(input int bp, output int who);
        int          w;
        bit          got;
        logic [3:0]  expf;
        who = -1;
        got = 0;
        #1;
        for (int k = 0; k < 12 && !got; k++) begin
            if (i0.req_ready === 1'b1 || i1.req_ready === 1'b1) got = 1;
            else to_next();
        end
        check("accept_seen", 32'(got), 1);
        if (!got) return;
        if (i0.req_valid && i1.req_valid) w = (last == 0) ? 1 : 0;
        else                              w = i1.req_valid ? 1 : 0;
        who     = w;
        acc_cyc = cyc;
        check("grant_ready0", 32'(i0.req_ready), 32'(w == 0));
        check("grant_ready1", 32'(i1.req_ready), 32'(w == 1));
        check("idle_busy", 32'(busy), 0);
        check("count_at_accept", 32'(done_count), cnt % 256);
        expf = (w == 0) ? alu_ref(i0.oc, i0.a, i0.b) : alu_ref(i1.oc, i1.a, i1.b);
        to_next();
        rand_req(w);
        if (bp > 0) set_resp_ready(w, 1'b0);
        #1;
        check("exec_busy", 32'(busy), 1);
        check("exec_ready", 32'({i0.req_ready, i1.req_ready}), 0);
        check("exec_rvalid", 32'({i0.resp_valid, i1.resp_valid}), 0);
        to_next();
        for (int k = 0; k <= bp; k++) begin
            if (k == bp) set_resp_ready(w, 1'b1);
            #1;
            check("resp_latency", cyc - acc_cyc, 2 + k);
            check("resp_valid", 32'({i1.resp_valid, i0.resp_valid}), (w == 1) ? 2 : 1);
            check("resp_f", 32'((w == 1) ? i1.resp_f : i0.resp_f), 32'(expf));
            check("other_f", 32'((w == 1) ? i0.resp_f : i1.resp_f), 0);
            check("resp_busy", 32'(busy), 1);
            check("resp_ready_low", 32'({i0.req_ready, i1.req_ready}), 0);
            if (k < bp) to_next();
        end
        last   = w;
        cnt    = cnt + 1;
        hs_cyc = cyc;
    endtask

    initial begin
        int          who;
        int          h;
        int          rel;
        bit          seen;
        logic [31:0] tv;

        set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        i0.resp_ready = 1'b1;
        i1.resp_ready = 1'b1;
        repeat (3) to_next();

        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(done_count), 0);
        check("rst_ready", 32'({i0.req_ready, i1.req_ready}), 0);
        check("rst_rvalid", 32'({i0.resp_valid, i1.resp_valid}), 0);
        check("rst_f", 32'({i0.resp_f, i1.resp_f}), 0);

        // Single request straight out of reset
        rst = 1'b0;
        set_req(0, 1'b1, 3'b000, 4'h3, 4'h5);
        rel = cyc;
        serve(0, who);
        check("single_who", who, 0);
        check("single_first_idle", acc_cyc, rel);
        set_valid(0, 1'b0);
        to_next(); #1;
        check("single_count", 32'(done_count), 1);
        check("single_idle", 32'(busy), 0);

        // Tie after reset
        do_reset();
        set_req(0, 1'b1, 3'b001, 4'hA, 4'h6);
        set_req(1, 1'b1, 3'b010, 4'hF, 4'h1);
        serve(0, who);
        check("tie_first", who, 0);
        set_valid(0, 1'b0);
        h = hs_cyc;
        serve(0, who);
        check("tie_second", who, 1);
        check("tie_gap", acc_cyc, h + 1);
        set_valid(1, 1'b0);
        to_next(); #1;
        check("tie_count", 32'(done_count), 2);

        // Round-robin fairness with both held valid
        do_reset();
        rand_req(0);
        rand_req(1);
        h = 0;
        for (int i = 0; i < 8; i++) begin
            serve(0, who);
            check("rr_order", who, i % 2);
            if (i > 0) check("rr_gap", acc_cyc, h + 1);
            h = hs_cyc;
        end
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        to_next(); #1;
        check("rr_count", 32'(done_count), 8);

        // Response backpressure on requester 1 while requester 0 waits
        do_reset();
        rand_req(0);
        serve(0, who);
        rand_req(1);
        serve(5, who);
        check("bp_who", who, 1);
        set_valid(1, 1'b0);
        serve(0, who);
        check("bp_next", who, 0);
        set_valid(0, 1'b0);
        to_next(); #1;
        check("bp_count", 32'(done_count), 3);

        // Every (oc, a, b) triple through requester 0
        do_reset();
        for (int t = 0; t < 2048; t++) begin
            tv = 32'(t);
            set_req(0, 1'b1, tv[10:8], tv[7:4], tv[3:0]);
            serve(0, who);
            check("exh_who", who, 0);
        end
        set_valid(0, 1'b0);
        to_next(); #1;
        check("exh_wrap", 32'(done_count), 0);

        // Randomized traffic; a pending request is never withdrawn
        do_reset();
        for (int r = 0; r < 40; r++) begin
            if (!i0.req_valid && $urandom_range(0, 1) == 1) rand_req(0);
            if (!i1.req_valid && $urandom_range(0, 1) == 1) rand_req(1);
            if (!i0.req_valid && !i1.req_valid) rand_req(int'($urandom_range(0, 1)));
            serve(int'($urandom_range(0, 2)), who);
            if (who >= 0 && $urandom_range(0, 1) == 1) set_valid(who, 1'b0);
        end
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        to_next(); #1;
        check("rand_count", 32'(done_count), cnt % 256);

        // Reset in the EXEC cycle discards the operation
        do_reset();
        rand_req(0);
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            #1;
            if (i0.req_ready === 1'b1) seen = 1;
            else to_next();
        end
        check("mid_accept", 32'(seen), 1);
        to_next(); #1;
        check("mid_exec_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_ready", 32'({i0.req_ready, i1.req_ready}), 0);
        check("mid_rvalid", 32'({i0.resp_valid, i1.resp_valid}), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_count", 32'(done_count), 0);
        to_next(); #1;
        check("mid_no_resp", 32'({i0.resp_valid, i1.resp_valid}), 0);
        rst  = 1'b0;
        cnt  = 0;
        last = 1;
        rand_req(1);
        serve(0, who);
        check("mid_tie_first", who, 0);
        set_valid(0, 1'b0);
        serve(0, who);
        check("mid_tie_second", who, 1);
        set_valid(1, 1'b0);
        to_next(); #1;
        check("mid_final_count", 32'(done_count), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
